// File: rtl/core_stim_pkg.sv
// Shared types and constants for the sequencer-to-L1 stimulus queue.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
// Contents: req_t request record, AMO_OP_W/BE_W field widths, and cnt_w()
// (bits needed to hold a count 0..n).
package core_stim_pkg;

   localparam int AMO_OP_W   = 5;
   localparam int BE_W       = 8;
   // Storage width of the address/data fields inside req_t. The top-level
   // ADDR_W/DATA_W must not exceed these.
   localparam int REQ_ADDR_W = 64;
   localparam int REQ_DATA_W = 64;

   typedef struct packed {
      logic                  we;
      logic [BE_W-1:0]       be;
      logic [REQ_ADDR_W-1:0] addr;
      logic [REQ_DATA_W-1:0] wdata;
      logic                  amo;
      logic                  lr;
      logic                  sc;
      logic [AMO_OP_W-1:0]   amo_op;
      logic                  amo_word;
   } req_t;

   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/core_stimulus_q_fifo.sv
// Generic synchronous FIFO (module stim_fifo), storage cleared by reset.
// Latency: 1 cycle push-to-visible; dat_o shows the head combinationally.
// Backpressure: push ignored when full, pop ignored when empty.
// Ports: clk, rst_n, push_i/dat_i (write), pop_i/dat_o (read head),
//        full_o, empty_o, cnt_o (occupancy 0..DEPTH). DEPTH need not be 2^n.
module stim_fifo
   import core_stim_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 4
)(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  logic [W-1:0]               dat_i,
   input  logic                       pop_i,
   output logic [W-1:0]               dat_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [cnt_w(DEPTH)-1:0]    cnt_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW    = cnt_w(DEPTH);

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    cnt_q;
   logic             do_push, do_pop;

   // Explicit wrap so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign cnt_o   = cnt_q;
   assign dat_o   = mem_q[rd_ptr_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= dat_i;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
         unique case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/core_stimulus_q.sv
// Sequencer-to-L1 stimulus queue: buffers requests, caps in-flight count, reports response latency.
// Latency: >=1 cycle sequencer accept to dut_req_o; responses pass through in 0 cycles.
// Backpressure: seq_gnt_o drops when the request FIFO is full; dut_req_o drops at MAX_OUTSTANDING.
// Ports: seq_* (sequencer side: req/gnt in, rvalid/rdata/rlat out), dut_* (L1 side: req/fields out,
//        gnt/rvalid/rdata in), outstanding_o, idle_o, err_o (sticky: response with nothing in flight),
//        stat_* (live only when CORE_STIM_STATS_EN is defined, otherwise tied to 0).
module core_stimulus_q
   import core_stim_pkg::*;
#(
   parameter int ADDR_W          = 64,   // <= REQ_ADDR_W
   parameter int DATA_W          = 64,   // <= REQ_DATA_W
   parameter int REQ_DEPTH       = 4,
   parameter int MAX_OUTSTANDING = 4,
   parameter int CNT_W           = 16
)(
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               seq_req_i,
   input  logic                               seq_we_i,
   input  logic [BE_W-1:0]                    seq_be_i,
   input  logic [ADDR_W-1:0]                  seq_addr_i,
   input  logic [DATA_W-1:0]                  seq_wdata_i,
   input  logic                               seq_amo_i,
   input  logic                               seq_lr_i,
   input  logic                               seq_sc_i,
   input  logic [AMO_OP_W-1:0]                seq_amo_op_i,
   input  logic                               seq_amo_word_i,
   output logic                               seq_gnt_o,
   output logic                               seq_rvalid_o,
   output logic [DATA_W-1:0]                  seq_rdata_o,
   output logic [CNT_W-1:0]                   seq_rlat_o,
   output logic                               dut_req_o,
   output logic                               dut_we_o,
   output logic [BE_W-1:0]                    dut_be_o,
   output logic [ADDR_W-1:0]                  dut_addr_o,
   output logic [DATA_W-1:0]                  dut_wdata_o,
   output logic                               dut_amo_o,
   output logic                               dut_lr_o,
   output logic                               dut_sc_o,
   output logic [AMO_OP_W-1:0]                dut_amo_op_o,
   output logic                               dut_amo_word_o,
   input  logic                               dut_gnt_i,
   input  logic                               dut_rvalid_i,
   input  logic [DATA_W-1:0]                  dut_rdata_i,
   output logic [cnt_w(MAX_OUTSTANDING)-1:0]  outstanding_o,
   output logic                               idle_o,
   output logic                               err_o,
   output logic [31:0]                        stat_req_cnt_o,
   output logic [31:0]                        stat_rsp_cnt_o,
   output logic [CNT_W-1:0]                   stat_max_lat_o
);

   req_t                            req_in, req_head;
   logic                            rq_full, rq_empty;
   logic [cnt_w(REQ_DEPTH)-1:0]     rq_cnt;
   logic [CNT_W-1:0]                ts_head;
   logic                            ts_full, ts_empty;
   logic [CNT_W-1:0]                cyc_q;
   logic                            err_q;
   logic                            grant, rsp_ok, rsp_err;

   always_comb begin
      req_in          = '0;
      req_in.we       = seq_we_i;
      req_in.be       = seq_be_i;
      req_in.addr     = REQ_ADDR_W'(seq_addr_i);
      req_in.wdata    = REQ_DATA_W'(seq_wdata_i);
      req_in.amo      = seq_amo_i;
      req_in.lr       = seq_lr_i;
      req_in.sc       = seq_sc_i;
      req_in.amo_op   = seq_amo_op_i;
      req_in.amo_word = seq_amo_word_i;
   end

   // rst_n gating keeps the combinational pass-through outputs quiet while in reset.
   assign seq_gnt_o    = rst_n && !rq_full;
   assign seq_rvalid_o = rst_n && dut_rvalid_i;
   assign seq_rdata_o  = rst_n ? dut_rdata_i : '0;

   // The timestamp FIFO holds exactly one entry per in-flight request, so its
   // occupancy is the outstanding count and its full flag is the issue cap.
   assign dut_req_o = !rq_empty && !ts_full;
   assign grant     = dut_req_o && dut_gnt_i;
   // Registered occupancy: a grant in the same cycle cannot cover a response.
   assign rsp_ok    = seq_rvalid_o && !ts_empty;
   assign rsp_err   = seq_rvalid_o && ts_empty;

   assign seq_rlat_o    = rsp_ok ? (cyc_q - ts_head) : '0;
   assign idle_o        = (rq_cnt == '0) && ts_empty;
   assign err_o         = err_q;

   assign dut_we_o       = req_head.we;
   assign dut_be_o       = req_head.be;
   assign dut_addr_o     = req_head.addr[ADDR_W-1:0];
   assign dut_wdata_o    = req_head.wdata[DATA_W-1:0];
   assign dut_amo_o      = req_head.amo;
   assign dut_lr_o       = req_head.lr;
   assign dut_sc_o       = req_head.sc;
   assign dut_amo_op_o   = req_head.amo_op;
   assign dut_amo_word_o = req_head.amo_word;

   stim_fifo #(.W($bits(req_t)), .DEPTH(REQ_DEPTH)) u_req_q (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (seq_req_i && seq_gnt_o),
      .dat_i   (req_in),
      .pop_i   (grant),
      .dat_o   (req_head),
      .full_o  (rq_full),
      .empty_o (rq_empty),
      .cnt_o   (rq_cnt)
   );

   stim_fifo #(.W(CNT_W), .DEPTH(MAX_OUTSTANDING)) u_ts_q (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (grant),
      .dat_i   (cyc_q),
      .pop_i   (rsp_ok),
      .dat_o   (ts_head),
      .full_o  (ts_full),
      .empty_o (ts_empty),
      .cnt_o   (outstanding_o)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc_q <= '0;
         err_q <= 1'b0;
      end else begin
         cyc_q <= cyc_q + 1'b1;
         if (rsp_err) err_q <= 1'b1;
      end
   end

`ifdef CORE_STIM_STATS_EN
   logic [31:0]      req_cnt_q, rsp_cnt_q;
   logic [CNT_W-1:0] max_lat_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_cnt_q <= '0;
         rsp_cnt_q <= '0;
         max_lat_q <= '0;
      end else begin
         if (grant && (req_cnt_q != '1)) req_cnt_q <= req_cnt_q + 1'b1;
         if (rsp_ok && (rsp_cnt_q != '1)) rsp_cnt_q <= rsp_cnt_q + 1'b1;
         if (rsp_ok && (seq_rlat_o > max_lat_q)) max_lat_q <= seq_rlat_o;
      end
   end

   assign stat_req_cnt_o = req_cnt_q;
   assign stat_rsp_cnt_o = rsp_cnt_q;
   assign stat_max_lat_o = max_lat_q;
`else
   assign stat_req_cnt_o = '0;
   assign stat_rsp_cnt_o = '0;
   assign stat_max_lat_o = '0;
`endif

endmodule

// File: tb/tb_core_stimulus_q.sv
// Self-checking bench for core_stimulus_q (REQ_DEPTH=4, MAX_OUTSTANDING=2, CNT_W=16).
// Directed scenarios followed by random traffic, all checked against a queue-based model.
// Inputs change on the falling edge and outputs are sampled 1 ns later.
module tb_core_stimulus_q;

   localparam int RD = 4;
   localparam int MO = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        seq_req_i = 0, seq_we_i = 0, seq_amo_i = 0, seq_lr_i = 0, seq_sc_i = 0, seq_amo_word_i = 0;
   logic [7:0]  seq_be_i = '0;
   logic [63:0] seq_addr_i = '0, seq_wdata_i = '0;
   logic [4:0]  seq_amo_op_i = '0;
   logic        seq_gnt_o, seq_rvalid_o;
   logic [63:0] seq_rdata_o;
   logic [15:0] seq_rlat_o;
   logic        dut_req_o, dut_we_o, dut_amo_o, dut_lr_o, dut_sc_o, dut_amo_word_o;
   logic [7:0]  dut_be_o;
   logic [63:0] dut_addr_o, dut_wdata_o;
   logic [4:0]  dut_amo_op_o;
   logic        dut_gnt_i = 0, dut_rvalid_i = 0;
   logic [63:0] dut_rdata_i = '0;
   logic [1:0]  outstanding_o;
   logic        idle_o, err_o;
   logic [31:0] stat_req_cnt_o, stat_rsp_cnt_o;
   logic [15:0] stat_max_lat_o;

   always #5 clk = ~clk;

   core_stimulus_q #(
      .ADDR_W(64), .DATA_W(64), .REQ_DEPTH(RD), .MAX_OUTSTANDING(MO), .CNT_W(16)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .seq_req_i(seq_req_i), .seq_we_i(seq_we_i), .seq_be_i(seq_be_i), .seq_addr_i(seq_addr_i),
      .seq_wdata_i(seq_wdata_i), .seq_amo_i(seq_amo_i), .seq_lr_i(seq_lr_i), .seq_sc_i(seq_sc_i),
      .seq_amo_op_i(seq_amo_op_i), .seq_amo_word_i(seq_amo_word_i),
      .seq_gnt_o(seq_gnt_o), .seq_rvalid_o(seq_rvalid_o), .seq_rdata_o(seq_rdata_o), .seq_rlat_o(seq_rlat_o),
      .dut_req_o(dut_req_o), .dut_we_o(dut_we_o), .dut_be_o(dut_be_o), .dut_addr_o(dut_addr_o),
      .dut_wdata_o(dut_wdata_o), .dut_amo_o(dut_amo_o), .dut_lr_o(dut_lr_o), .dut_sc_o(dut_sc_o),
      .dut_amo_op_o(dut_amo_op_o), .dut_amo_word_o(dut_amo_word_o),
      .dut_gnt_i(dut_gnt_i), .dut_rvalid_i(dut_rvalid_i), .dut_rdata_i(dut_rdata_i),
      .outstanding_o(outstanding_o), .idle_o(idle_o), .err_o(err_o),
      .stat_req_cnt_o(stat_req_cnt_o), .stat_rsp_cnt_o(stat_rsp_cnt_o), .stat_max_lat_o(stat_max_lat_o)
   );

   typedef struct {
      logic        we;
      logic [7:0]  be;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic        amo, lr, sc;
      logic [4:0]  op;
      logic        aw;
   } mreq_t;

   // Model state: queued requests, grant cycle of each in-flight request, sticky error, statistics.
   mreq_t q_req[$];
   int    q_inf[$];
   bit    err_m;
   int    st_req, st_rsp, st_max;
   int    checks = 0, failures = 0;

   // Clock cycles since reset release: the time base latencies are measured against.
   int cyc = 0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: apply inputs, compare every output with the model, then advance the model.
   task automatic cycle(input bit sreq, input logic [63:0] addr, input bit gnt, input bit rv,
                        input logic [63:0] rdata);
      mreq_t       r;
      bit          exp_req, exp_gnt;
      int          n_inf;
      logic [15:0] exp_lat;
      @(negedge clk);
      r.we = 1'($urandom); r.be = 8'($urandom); r.addr = addr; r.wdata = {$urandom, $urandom};
      r.amo = 1'($urandom); r.lr = 1'($urandom); r.sc = 1'($urandom);
      r.op = 5'($urandom); r.aw = 1'($urandom);
      seq_req_i = sreq; seq_we_i = r.we; seq_be_i = r.be; seq_addr_i = r.addr; seq_wdata_i = r.wdata;
      seq_amo_i = r.amo; seq_lr_i = r.lr; seq_sc_i = r.sc; seq_amo_op_i = r.op; seq_amo_word_i = r.aw;
      dut_gnt_i = gnt; dut_rvalid_i = rv; dut_rdata_i = rdata;
      #1;
      n_inf   = q_inf.size();
      exp_gnt = q_req.size() < RD;
      exp_req = (q_req.size() > 0) && (n_inf < MO);
      chk("seq_gnt", seq_gnt_o, exp_gnt);
      chk("dut_req", dut_req_o, exp_req);
      if (exp_req) begin
         chk("dut_addr", dut_addr_o, q_req[0].addr);
         chk("dut_wdata", dut_wdata_o, q_req[0].wdata);
         chk("dut_ctl", {dut_we_o, dut_be_o, dut_amo_o, dut_lr_o, dut_sc_o, dut_amo_op_o, dut_amo_word_o},
             {q_req[0].we, q_req[0].be, q_req[0].amo, q_req[0].lr, q_req[0].sc, q_req[0].op, q_req[0].aw});
      end
      chk("rvalid", seq_rvalid_o, rv);
      chk("rdata", seq_rdata_o, rdata);
      exp_lat = (rv && n_inf > 0) ? 16'(cyc - q_inf[0]) : 16'd0;
      chk("rlat", seq_rlat_o, exp_lat);
      chk("outstanding", outstanding_o, n_inf);
      chk("idle", idle_o, (q_req.size() == 0) && (n_inf == 0));
      chk("err", err_o, err_m);
`ifdef CORE_STIM_STATS_EN
      chk("st_req", stat_req_cnt_o, st_req);
      chk("st_rsp", stat_rsp_cnt_o, st_rsp);
      chk("st_max", stat_max_lat_o, st_max);
`else
      chk("st_tied", {stat_req_cnt_o, stat_rsp_cnt_o} | 64'(stat_max_lat_o), 64'd0);
`endif
      if (rv) begin
         if (n_inf > 0) begin
            void'(q_inf.pop_front());
            st_rsp++;
            if (int'(exp_lat) > st_max) st_max = int'(exp_lat);
         end else begin
            err_m = 1'b1;
         end
      end
      if (exp_req && gnt) begin
         void'(q_req.pop_front());
         q_inf.push_back(cyc);
         st_req++;
      end
      if (sreq && exp_gnt) q_req.push_back(r);
   endtask

   task automatic idle_cyc();
      cycle(1'b0, 64'd0, 1'b0, 1'b0, 64'd0);
   endtask

   // Run idle cycles so that the next cycle() call executes at cycle number n.
   task automatic idle_until(input int n);
      while (cyc < n - 1) idle_cyc();
   endtask

   // Hold reset for one full clock with hostile inputs applied, checking the in-reset outputs.
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      seq_req_i = 1'b1; dut_gnt_i = 1'b1; dut_rvalid_i = 1'b1;
      dut_rdata_i = 64'hA5A5_5A5A_DEAD_0001; seq_addr_i = 64'h1234;
      #1;
      chk("rst_seq_gnt", seq_gnt_o, 0);
      chk("rst_dut_req", dut_req_o, 0);
      chk("rst_rvalid", seq_rvalid_o, 0);
      chk("rst_rdata", seq_rdata_o, 0);
      chk("rst_rlat", seq_rlat_o, 0);
      chk("rst_idle", idle_o, 1);
      chk("rst_outstanding", outstanding_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_addr", dut_addr_o, 0);
      chk("rst_wdata", dut_wdata_o, 0);
      chk("rst_stats", {stat_req_cnt_o, stat_rsp_cnt_o} | 64'(stat_max_lat_o), 0);
      q_req.delete(); q_inf.delete();
      err_m = 1'b0; st_req = 0; st_rsp = 0; st_max = 0;
      @(negedge clk);
      rst_n = 1'b1;
      seq_req_i = 1'b0; dut_gnt_i = 1'b0; dut_rvalid_i = 1'b0; dut_rdata_i = '0;
   endtask

   // Grant and answer everything outstanding, bounded.
   task automatic drain();
      for (int i = 0; i < 40 && (q_req.size() > 0 || q_inf.size() > 0); i++)
         cycle(1'b0, 64'd0, 1'b1, q_inf.size() > 0, {$urandom, $urandom});
      idle_cyc();
      chk("drain_idle", idle_o, 1);
   endtask

   initial begin
      do_reset();

      // Backpressure: no grants, five pushes, only four fit.
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 64'h1000 + 64'(16 * i), 1'b0, 1'b0, 64'd0);
         chk("bp_seq_gnt", seq_gnt_o, (i < 4));
      end
      for (int i = 0; i < 2; i++) begin
         idle_cyc();
         chk("bp_dut_req", dut_req_o, 1);
         chk("bp_head_addr", dut_addr_o, 64'h1000);
      end

      // Outstanding cap at 2.
      cycle(1'b0, 64'd0, 1'b1, 1'b0, 64'd0);
      cycle(1'b0, 64'd0, 1'b1, 1'b0, 64'd0);
      cycle(1'b0, 64'd0, 1'b1, 1'b0, 64'd0);
      chk("cap_dut_req", dut_req_o, 0);
      chk("cap_outstanding", outstanding_o, 2);
      cycle(1'b0, 64'd0, 1'b1, 1'b1, 64'h1111);
      chk("cap_req_same_cycle", dut_req_o, 0);
      idle_cyc();
      chk("cap_req_reassert", dut_req_o, 1);
      chk("cap_outstanding_1", outstanding_o, 1);
      chk("cap_head_addr", dut_addr_o, 64'h1020);

      // Grant and response in the same cycle with one in flight.
      cycle(1'b0, 64'd0, 1'b1, 1'b1, 64'h2222);
      chk("sim_outstanding", outstanding_o, 1);
      chk("sim_lat_older", seq_rlat_o, 4);
      idle_cyc();
      chk("sim_outstanding_after", outstanding_o, 1);
      drain();

      // Spurious response at idle.
      cycle(1'b0, 64'd0, 1'b0, 1'b1, 64'h3333);
      chk("spur_lat", seq_rlat_o, 0);
      idle_cyc();
      chk("spur_err", err_o, 1);
      chk("spur_outstanding", outstanding_o, 0);
      chk("spur_idle", idle_o, 1);
      idle_cyc();
      chk("spur_err_sticky", err_o, 1);

      // Reset with three queued and two in flight.
      cycle(1'b1, 64'h2000, 1'b0, 1'b0, 64'd0);
      cycle(1'b1, 64'h2010, 1'b1, 1'b0, 64'd0);
      cycle(1'b1, 64'h2020, 1'b1, 1'b0, 64'd0);
      cycle(1'b1, 64'h2030, 1'b1, 1'b0, 64'd0);
      cycle(1'b1, 64'h2040, 1'b0, 1'b0, 64'd0);
      chk("mid_outstanding", outstanding_o, 2);
      do_reset();
      idle_cyc();
      chk("mid_idle", idle_o, 1);
      chk("mid_seq_gnt", seq_gnt_o, 1);
      chk("mid_stat_req", stat_req_cnt_o, 0);
      chk("mid_stat_rsp", stat_rsp_cnt_o, 0);
      chk("mid_stat_max", stat_max_lat_o, 0);
      cycle(1'b0, 64'd0, 1'b0, 1'b1, 64'h4444);
      idle_cyc();
      chk("mid_late_rsp_err", err_o, 1);

      // Latency: grant at cycle 10, response at cycle 17.
      do_reset();
      idle_until(9);
      cycle(1'b1, 64'h3000, 1'b0, 1'b0, 64'd0);
      cycle(1'b0, 64'd0, 1'b1, 1'b0, 64'd0);
      idle_until(17);
      cycle(1'b0, 64'd0, 1'b0, 1'b1, 64'hDEAD_BEEF);
      chk("lat_rvalid", seq_rvalid_o, 1);
      chk("lat_rdata", seq_rdata_o, 64'hDEAD_BEEF);
      chk("lat_value", seq_rlat_o, 7);

      // Latency across counter wrap: grant at 0xFFFE, response at 0x10003.
      idle_until(65533);
      cycle(1'b1, 64'h4000, 1'b0, 1'b0, 64'd0);
      cycle(1'b0, 64'd0, 1'b1, 1'b0, 64'd0);
      idle_until(65539);
      cycle(1'b0, 64'd0, 1'b0, 1'b1, 64'h5555);
      chk("wrap_lat", seq_rlat_o, 5);

      // Random traffic.
      for (int i = 0; i < 3000; i++)
         cycle(1'($urandom_range(0, 1)), {$urandom, $urandom}, $urandom_range(0, 9) < 6,
               (q_inf.size() > 0) && ($urandom_range(0, 9) < 4), {$urandom, $urandom});
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
